// File: rtl/sa_instr_buf_axil_slave_if.sv
// AXI4-Lite bus bundle for the systolic-array instruction buffer slave.
interface sa_instr_buf_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sa_instr_buf_axil_slave.sv
// AXI4-Lite slave queueing 32-bit instruction words into a FIFO drained over a valid/ready stream.
// Define SA_IBUF_IRQ_EN to add the registered irq output (DONE | OVF).
module sa_instr_buf_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  sa_instr_buf_axil_slave_if.slave      s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] instr_data,
  output logic                          instr_valid,
  input  logic                          instr_ready
`ifdef SA_IBUF_IRQ_EN
  ,
  output logic                          irq
`endif
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] REG_INSTR   = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [0:0]    w_state_q, w_state_d, r_state_q, r_state_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [DW-1:0] last_q, last_d;
  logic          enable_q, enable_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];

  logic          wr_fire, rd_fire, full, empty, pop, push_req, strb_ok, push, flush;
  logic [AW-3:0] wr_sel, rd_sel;
  logic [DW-1:0] status_word, rd_word;
  logic          unused_ok;

  assign wr_fire = (w_state_q == W_IDLE) & s_axi.awvalid & s_axi.wvalid;
  assign rd_fire = (r_state_q == R_IDLE) & s_axi.arvalid;
  assign wr_sel  = s_axi.awaddr[AW-1:2];
  assign rd_sel  = s_axi.araddr[AW-1:2];

  assign s_axi.awready = wr_fire;
  assign s_axi.wready  = wr_fire;
  assign s_axi.arready = rd_fire;
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign instr_valid = enable_q & ~empty;
  assign instr_data  = mem_q[rd_ptr_q];
  assign pop         = instr_valid & instr_ready;

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room for a push.
  assign push_req = wr_fire & (wr_sel == REG_INSTR);
  assign strb_ok  = (s_axi.wstrb == {SW{1'b1}});
  assign push     = push_req & strb_ok & ~full;
  assign flush    = wr_fire & (wr_sel == REG_CTRL) & s_axi.wstrb[0] & s_axi.wdata[0];

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_comb begin
    status_word        = '0;
    status_word[7:0]   = 8'(count_q);
    status_word[8]     = empty;
    status_word[9]     = full;
    status_word[10]    = ovf_q;
    status_word[11]    = done_q;
    rd_word            = '0;
    case (rd_sel)
      REG_INSTR:   rd_word = last_q;
      REG_CTRL:    rd_word[1] = enable_q;
      REG_STATUS:  rd_word = status_word;
      REG_SCRATCH: rd_word = scratch_q;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    scratch_d = scratch_q;
    last_d    = last_q;
    enable_d  = enable_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (wr_fire) begin
      w_state_d = W_RESP;
      bresp_d   = (push_req & ~(strb_ok & ~full)) ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi.bready) begin
      w_state_d = W_IDLE;
    end

    if (rd_fire) begin
      r_state_d = R_DATA;
      rdata_d   = rd_word;
    end else if (s_axi.rready) begin
      r_state_d = R_IDLE;
    end

    if (wr_fire && wr_sel == REG_CTRL && s_axi.wstrb[0]) enable_d = s_axi.wdata[1];
    if (wr_fire && wr_sel == REG_SCRATCH) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi.wstrb[b]) scratch_d[8*b +: 8] = s_axi.wdata[8*b +: 8];
      end
    end
    if (wr_fire && wr_sel == REG_STATUS && s_axi.wstrb[1]) begin
      if (s_axi.wdata[10]) ovf_d  = 1'b0;
      if (s_axi.wdata[11]) done_d = 1'b0;
    end
    if (push_req && strb_ok && full) ovf_d = 1'b1;

    // Flush overrides any pop in the same cycle and never counts as draining.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        last_d   = s_axi.wdata;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
      if (pop && !push && count_q == CW'(1)) done_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      scratch_q <= '0;
      last_q    <= '0;
      enable_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      last_q    <= last_d;
      enable_q  <= enable_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= s_axi.wdata;
  end

`ifdef SA_IBUF_IRQ_EN
  logic irq_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) irq_q <= 1'b0;
    else                irq_q <= ovf_d | done_d;
  end

  assign irq = irq_q;
`endif
endmodule

// File: tb/tb_sa_instr_buf_axil_slave.sv
// Bench for sa_instr_buf_axil_slave: directed vector table, corner sequences, and random
// traffic checked each cycle against a queue-based reference model.
module tb_sa_instr_buf_axil_slave;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        instr_ready;
`ifdef SA_IBUF_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  sa_instr_buf_axil_slave_if bus ();

  sa_instr_buf_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .instr_data    (instr_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
`ifdef SA_IBUF_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timed out (t=%0t)", name, $time);
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    while (!(bus.awready && bus.wready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout_fail("wr_addr");
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout_fail("wr_resp");
    resp = bus.bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout_fail("rd_addr");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout_fail("rd_data");
    d = bus.rdata; resp = bus.rresp;
    @(posedge clk); #1;
  endtask

  // Reference model: FIFO as a queue, registers as plain variables, advanced once per cycle.
  logic [31:0] mq[$];
  logic        m_en, m_ovf, m_done, m_bv, m_rv;
  logic [1:0]  m_bresp;
  logic [31:0] m_rdata, m_last, m_scr;

  initial begin : model
    logic        pop, wr, rd, push, flush;
    logic [31:0] st, wd;
    logic [3:0]  sb;
    logic [1:0]  ws, rs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_en = 0; m_ovf = 0; m_done = 0; m_bv = 0; m_rv = 0;
        m_bresp = 0; m_rdata = 0; m_last = 0; m_scr = 0;
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_ivalid", instr_valid, 0);
      end else begin
        check("mdl_ivalid", instr_valid, m_en && mq.size() != 0);
        if (m_en && mq.size() != 0) check("mdl_idata", instr_data, mq[0]);
        check("mdl_awready", bus.awready, !m_bv && bus.awvalid && bus.wvalid);
        check("mdl_wready", bus.wready, !m_bv && bus.awvalid && bus.wvalid);
        check("mdl_arready", bus.arready, !m_rv && bus.arvalid);
        check("mdl_bvalid", bus.bvalid, m_bv);
        if (m_bv) check("mdl_bresp", bus.bresp, m_bresp);
        check("mdl_rvalid", bus.rvalid, m_rv);
        if (m_rv) begin
          check("mdl_rdata", bus.rdata, m_rdata);
          check("mdl_rresp", bus.rresp, 0);
        end

        pop = m_en && mq.size() != 0 && instr_ready;
        wr  = !m_bv && bus.awvalid && bus.wvalid;
        rd  = !m_rv && bus.arvalid;
        ws  = bus.awaddr[3:2]; rs = bus.araddr[3:2];
        wd  = bus.wdata;       sb = bus.wstrb;
        st  = 32'(mq.size()) | (mq.size() == 0 ? 32'h100 : 0) | (mq.size() == DEPTH ? 32'h200 : 0)
            | (m_ovf ? 32'h400 : 0) | (m_done ? 32'h800 : 0);
        push = 0; flush = 0;

        if (rd) begin
          m_rv = 1;
          case (rs)
            2'd0: m_rdata = m_last;
            2'd1: m_rdata = {30'd0, m_en, 1'b0};
            2'd2: m_rdata = st;
            default: m_rdata = m_scr;
          endcase
        end else if (m_rv && bus.rready) m_rv = 0;

        if (wr) begin
          m_bv = 1; m_bresp = 2'b00;
          case (ws)
            2'd0: begin
              if (sb != 4'hF) m_bresp = 2'b10;
              else if (mq.size() == DEPTH) begin m_bresp = 2'b10; m_ovf = 1; end
              else push = 1;
            end
            2'd1: if (sb[0]) begin flush = wd[0]; m_en = wd[1]; end
            2'd2: if (sb[1]) begin
              if (wd[10]) m_ovf = 0;
              if (wd[11]) m_done = 0;
            end
            default: for (int b = 0; b < 4; b++) if (sb[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
          endcase
        end else if (m_bv && bus.bready) m_bv = 0;

        if (flush) mq.delete();
        else begin
          if (pop) void'(mq.pop_front());
          if (push) begin mq.push_back(wd); m_last = wd; end
          if (pop && mq.size() == 0) m_done = 1;
        end
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[14];
  logic [1:0]  resp;
  logic [31:0] rd;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'h8, 32'h0,        4'h0, 2'b00, 32'h0000_0100};
    vecs[1]  = '{1'b0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h0000_0000};
    vecs[2]  = '{1'b0, 4'hC, 32'h0,        4'h0, 2'b00, 32'h0000_0000};
    vecs[3]  = '{1'b1, 4'h0, 32'h1,        4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 32'h2,        4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1'b1, 4'h0, 32'h3,        4'hF, 2'b00, 32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h4,        4'hF, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,        4'h0, 2'b00, 32'h0000_0004};
    vecs[8]  = '{1'b0, 4'h0, 32'h0,        4'h0, 2'b00, 32'h0000_0004};
    vecs[9]  = '{1'b1, 4'h0, 32'h5,        4'h7, 2'b10, 32'h0};
    vecs[10] = '{1'b0, 4'h8, 32'h0,        4'h0, 2'b00, 32'h0000_0004};
    vecs[11] = '{1'b1, 4'hC, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0};
    vecs[12] = '{1'b1, 4'hC, 32'h12345678, 4'h5, 2'b00, 32'h0};
    vecs[13] = '{1'b0, 4'hC, 32'h0,        4'h0, 2'b00, 32'hA534_A578};

    rst_n = 1'b0;
    instr_ready = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
        check($sformatf("tbl%0d_bresp", i), resp, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("tbl%0d_rresp", i), resp, vecs[i].exp_resp);
      end
    end
    check("t1_ivalid_disabled", instr_valid, 0);

    // Enable and drain four words on consecutive cycles.
    axi_write(4'h4, 32'h2, 4'hF, resp);
    check("t2_ctrl_bresp", resp, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_ivalid", instr_valid, 1);
      check("t2_idata", instr_data, i + 1);
      @(posedge clk); #1;
    end
    check("t2_ivalid_empty", instr_valid, 0);
    axi_read(4'h8, rd, resp);
    check("t2_status_done", rd, 32'h900);
    axi_write(4'h8, 32'h800, 4'hF, resp);
    axi_read(4'h8, rd, resp);
    check("t2_status_w1c", rd, 32'h100);

    // Fill to full, overflow, then clear OVF.
    axi_write(4'h4, 32'h0, 4'hF, resp);
    for (int i = 0; i < DEPTH; i++) begin
      axi_write(4'h0, 32'h100 + i, 4'hF, resp);
      check("t3_fill_bresp", resp, 0);
    end
    axi_write(4'h0, 32'hDEAD, 4'hF, resp);
    check("t3_ovf_bresp", resp, 2'b10);
    axi_read(4'h8, rd, resp);
    check("t3_status_ovf", rd, 32'h610);
    axi_write(4'h8, 32'h400, 4'hF, resp);
    axi_read(4'h8, rd, resp);
    check("t3_status_ovf_clr", rd, 32'h210);
    axi_read(4'h0, rd, resp);
    check("t3_last_push", rd, 32'h10F);

    // Flush while a pop is offered in the same cycle.
    instr_ready = 1'b0;
    axi_write(4'h4, 32'h2, 4'hF, resp);
    check("t4_ivalid_full", instr_valid, 1);
    instr_ready = 1'b1;
    axi_write(4'h4, 32'h3, 4'hF, resp);
    check("t4_ivalid_flushed", instr_valid, 0);
    axi_read(4'h8, rd, resp);
    check("t4_status_flushed", rd, 32'h100);
    axi_read(4'h4, rd, resp);
    check("t4_ctrl_readback", rd, 32'h2);

    // Held write response blocks the next write; read channel stays independent.
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 4'h0; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1 check("t6_awready_first", bus.awready, 1);
    @(posedge clk); #1;
    bus.awaddr = 4'hC; bus.wdata = 32'hCAFE_F00D;
    bus.araddr = 4'hC; bus.arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t6_bvalid_hold", bus.bvalid, 1);
      check("t6_awready_low", bus.awready, 0);
      if (i == 0) check("t6_arready", bus.arready, 1);
      if (i >= 1) begin
        check("t6_rvalid_hold", bus.rvalid, 1);
        check("t6_rdata", bus.rdata, 32'hA534_A578);
      end
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    check("t6_awready_resume", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t6_second_bvalid", bus.bvalid, 1);
    check("t6_second_bresp", bus.bresp, 0);
    @(posedge clk); #1;
    check("t6_rvalid_before_rst", bus.rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid", bus.rvalid, 0);
    check("t6_rst_bvalid", bus.bvalid, 0);
    check("t6_rst_ivalid", instr_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.rready = 1'b1;
    axi_read(4'h8, rd, resp);
    check("t6_status_after_rst", rd, 32'h100);
    axi_read(4'hC, rd, resp);
    check("t6_scratch_after_rst", rd, 32'h0);

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      instr_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      a = (r < 5) ? 4'h0 : (r == 5) ? 4'h4 : (r < 8) ? 4'h8 : 4'hC;
      d = $urandom;
      if (a == 4'h4) d[0] = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 1) == 1) axi_write(a, d, s, resp);
      else                           axi_read(a, rd, resp);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
